// File: rtl/range_classifier.sv
// Range classifier: bins NUM into below/inside/above and reports the class only after
// PERSIST consecutive agreeing samples. Define RANGE_CLASSIFIER_STATS_EN for per-class counters.
module range_classifier #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LO      = 4,
  parameter int unsigned HI      = 11,
  parameter int unsigned PERSIST = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] NUM,
  output logic [2:0]       OUT,
  output logic             out_valid,
  output logic             changed,
  output logic [CNT_W-1:0] cnt_below,
  output logic [CNT_W-1:0] cnt_inside,
  output logic [CNT_W-1:0] cnt_above
);

  if (LO > HI) begin : g_bad_range
    $error("range_classifier: LO must not exceed HI");
  end
  if (PERSIST < 1) begin : g_bad_persist
    $error("range_classifier: PERSIST must be at least 1");
  end

  localparam int unsigned RUN_W = $clog2(PERSIST + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(PERSIST);

  typedef enum logic [1:0] {IDLE, STABLE, PENDING} state_t;

  state_t           state_q, state_n;
  logic [2:0]       out_n, cand_q, cand_n, raw;
  logic [RUN_W-1:0] run_q, run_n, run_inc;
  logic             chg_n;

  always_comb begin
    raw = 3'b010;
    if (32'(NUM) < LO)      raw = 3'b001;
    else if (32'(NUM) > HI) raw = 3'b100;
  end

  assign run_inc = run_q + RUN_W'(1);

  always_comb begin
    state_n = state_q;
    out_n   = OUT;
    cand_n  = cand_q;
    run_n   = run_q;
    chg_n   = 1'b0;
    if (in_valid) begin
      case (state_q)
        IDLE: begin
          out_n   = raw;
          chg_n   = 1'b1;
          state_n = STABLE;
        end
        STABLE: begin
          if (raw != OUT) begin
            if (PERSIST == 1) begin
              out_n = raw;
              chg_n = 1'b1;
            end else begin
              cand_n  = raw;
              run_n   = RUN_W'(1);
              state_n = PENDING;
            end
          end
        end
        PENDING: begin
          // candidate is never equal to OUT here, so the match order is unambiguous
          if (raw == cand_q) begin
            if (run_inc == RUN_MAX) begin
              out_n   = cand_q;
              chg_n   = 1'b1;
              cand_n  = '0;
              run_n   = '0;
              state_n = STABLE;
            end else begin
              run_n = run_inc;
            end
          end else if (raw == OUT) begin
            cand_n  = '0;
            run_n   = '0;
            state_n = STABLE;
          end else begin
            cand_n = raw;
            run_n  = RUN_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      OUT       <= '0;
      cand_q    <= '0;
      run_q     <= '0;
      out_valid <= 1'b0;
      changed   <= 1'b0;
    end else begin
      state_q   <= state_n;
      OUT       <= out_n;
      cand_q    <= cand_n;
      run_q     <= run_n;
      out_valid <= in_valid;
      changed   <= chg_n;
    end
  end

`ifdef RANGE_CLASSIFIER_STATS_EN
  // counts follow the class reported alongside each out_valid, saturating at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_below  <= '0;
      cnt_inside <= '0;
      cnt_above  <= '0;
    end else if (in_valid) begin
      case (out_n)
        3'b001:  if (cnt_below  != '1) cnt_below  <= cnt_below  + CNT_W'(1);
        3'b010:  if (cnt_inside != '1) cnt_inside <= cnt_inside + CNT_W'(1);
        3'b100:  if (cnt_above  != '1) cnt_above  <= cnt_above  + CNT_W'(1);
        default: ;
      endcase
    end
  end
`else
  assign cnt_below  = '0;
  assign cnt_inside = '0;
  assign cnt_above  = '0;
`endif

endmodule
